// File: rtl/aes_uart_sequencer.sv
// ---------------------------------------------------------------------------
// aes_uart_sequencer
//
// Sits between the UART receive path, the AES core and the transmitter
// buffer. Sixteen received bytes are packed MSB-first into a 128-bit block,
// the AES core is started with a one-cycle pulse, its result is latched and
// handed to the transmitter buffer with a single-cycle ready strobe.
//
// Optional feature (macro SEQ_BYTE_TIMEOUT_EN):
//   When defined, a partial block is discarded silently if no byte arrives
//   for BYTE_TIMEOUT cycles. When undefined, COLLECT waits forever and
//   BYTE_TIMEOUT has no effect.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   rx_byte        received UART byte
//   rx_valid       one-cycle strobe qualifying rx_byte
//   aes_block_in   plaintext block to AES core (stable from START to IDLE)
//   aes_start      one-cycle AES start pulse
//   aes_done       one-cycle AES completion strobe
//   aes_block_out  AES result, sampled when aes_done=1
//   block_to_tx    block for the transmitter buffer (holds last result)
//   tx_ready       one-cycle push strobe to the transmitter buffer
//   tx_overflow    transmitter buffer full level; stalls the push
//   busy           high in every state except IDLE
//   drop_err       sticky: a byte arrived while not collecting
//   aes_err        sticky: AES core did not answer within AES_TIMEOUT cycles
// ---------------------------------------------------------------------------
module aes_uart_sequencer #(
  parameter int AES_TIMEOUT  = 1024,
  parameter int BYTE_TIMEOUT = 100000,
  parameter int CNT_W        = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [127:0] aes_block_in,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_block_out,
  output logic [127:0] block_to_tx,
  output logic         tx_ready,
  input  logic         tx_overflow,
  output logic         busy,
  output logic         drop_err,
  output logic         aes_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    START    = 3'd2,
    WAIT_AES = 3'd3,
    PUSH     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] AES_LAST  = CNT_W'(AES_TIMEOUT - 1);
`ifdef SEQ_BYTE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TIMEOUT - 1);
`endif

  state_t           state_q, state_d;
  logic [4:0]       byte_cnt;   // bytes captured so far, reaches 16 on a full block
  logic [CNT_W-1:0] tmo_cnt;    // shared between AES wait and byte gap timing
  logic [6:0]       wr_lsb;     // LSB of the slot for the next byte
  logic             aes_tmo;
  logic             byte_tmo;
  logic             drop_state;

  // Byte k lands at [127-8k -: 8], i.e. LSB = 8*(15-k); 15-k == ~k on 4 bits.
  assign wr_lsb  = {~byte_cnt[3:0], 3'b000};
  assign aes_tmo = (tmo_cnt == AES_LAST);

`ifdef SEQ_BYTE_TIMEOUT_EN
  assign byte_tmo = (tmo_cnt == BYTE_LAST);
`else
  assign byte_tmo = 1'b0;
`endif

  // States in which an incoming byte has nowhere to go.
  assign drop_state = (state_q == START) || (state_q == WAIT_AES) ||
                      (state_q == PUSH)  || (state_q == ERROR);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next state and strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    aes_start = 1'b0;
    tx_ready  = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (rx_valid) state_d = COLLECT;
      end
      COLLECT: begin
        if (rx_valid) begin
          if (byte_cnt == 5'd15) state_d = START;
        end else if (byte_tmo) begin
          state_d = IDLE;
        end
      end
      START: begin
        aes_start = 1'b1;
        state_d   = WAIT_AES;
      end
      WAIT_AES: begin
        // Completion takes priority over a coincident timeout.
        if (aes_done)     state_d = PUSH;
        else if (aes_tmo) state_d = ERROR;
      end
      PUSH: begin
        if (!tx_overflow) begin
          tx_ready = 1'b1;
          state_d  = IDLE;
        end
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: block assembly, counters, result latch, sticky flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aes_block_in <= '0;
      block_to_tx  <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      drop_err     <= 1'b0;
      aes_err      <= 1'b0;
    end else begin
      if (rx_valid && drop_state) drop_err <= 1'b1;

      case (state_q)
        IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid) begin
            aes_block_in[127:120] <= rx_byte;
            byte_cnt              <= 5'd1;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            aes_block_in[wr_lsb +: 8] <= rx_byte;
            byte_cnt                  <= byte_cnt + 5'd1;
          end
`ifdef SEQ_BYTE_TIMEOUT_EN
          // Gap timer restarts on every byte; expiry silently drops the
          // partial block (stale bytes are overwritten by the next block).
          if (rx_valid) begin
            tmo_cnt <= '0;
          end else if (byte_tmo) begin
            tmo_cnt  <= '0;
            byte_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        START: begin
          tmo_cnt  <= '0;
          byte_cnt <= '0;
        end
        WAIT_AES: begin
          if (aes_done)     block_to_tx <= aes_block_out;
          else if (aes_tmo) aes_err     <= 1'b1;
          else              tmo_cnt     <= tmo_cnt + CNT_W'(1);
        end
        ERROR: begin
          byte_cnt <= '0;
          tmo_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_uart_sequencer.md
Name: aes_uart_sequencer

Overview:
- Top-level sequencer between the UART receive path, the AES core and the transmitter buffer.
- Assembles 16 received bytes into a 128-bit block and starts the AES core.
- Waits for AES completion, then pushes the result block into the transmitter buffer with a single-cycle ready pulse.
- Owns the rx-byte drop policy and reports errors.

Parameters:
- AES_TIMEOUT, 1024: max cycles in WAIT_AES before aborting to ERROR.
- BYTE_TIMEOUT, 100000: max idle cycles between bytes inside a partial block (used only with SEQ_BYTE_TIMEOUT_EN).
- CNT_W, 20: width of the shared timeout counter; must hold max(AES_TIMEOUT, BYTE_TIMEOUT).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_byte  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- aes_block_in  out  128  plaintext block to AES core
- aes_start  out  1  one-cycle AES start pulse
- aes_done  in  1  one-cycle AES completion strobe
- aes_block_out  in  128  AES result, valid when aes_done=1
- block_to_tx  out  128  block to transmitter buffer (block_aes_to_UART_tx)
- tx_ready  out  1  one-cycle push strobe to transmitter buffer (its ready input)
- tx_overflow  in  1  transmitter buffer overflow/full level
- busy  out  1  high in any state except IDLE
- drop_err  out  1  sticky: rx byte arrived while not collecting
- aes_err  out  1  sticky: AES timeout occurred

Behaviour:
- Reset (async, any state): state=IDLE, byte count=0, timeout counter=0; all outputs 0, including aes_block_in, block_to_tx, aes_start, tx_ready, busy, drop_err and aes_err.
- States: IDLE, COLLECT, START, WAIT_AES, PUSH, ERROR.
- IDLE: on rx_valid, store the byte in bits [127:120], set count=1, go to COLLECT.
- COLLECT: each rx_valid shifts the byte in MSB-first (byte k lands at [127-8k -: 8]) and increments count.
  - When the 16th byte is captured (count reaches 16), go to START in the next cycle.
  - aes_block_in updates only in IDLE/COLLECT and is held stable from START until the next IDLE.
- START: aes_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_AES.
  - Latency: 16th rx_valid at cycle N gives aes_start=1 at cycle N+1.
- WAIT_AES: the timeout counter increments each cycle.
  - On aes_done: latch aes_block_out into block_to_tx and go to PUSH.
  - If the counter reaches AES_TIMEOUT-1 without aes_done: set aes_err and go to ERROR.
  - If aes_done and timeout coincide, aes_done wins.
- PUSH: if tx_overflow=0, tx_ready=1 for one cycle, then go to IDLE.
  - If tx_overflow=1, hold in PUSH with tx_ready=0 until it deasserts; no timeout applies.
  - Latency: aes_done at cycle M with no overflow gives tx_ready at M+1.
- ERROR: one cycle; clear count; return to IDLE. aes_err stays set until reset.
- rx_valid in START, WAIT_AES, PUSH or ERROR: the byte is discarded and drop_err is set (sticky). This applies even when rx_valid coincides with the state transition out of COLLECT on the 16th byte.
- block_to_tx holds its last value after PUSH.
- Exactly one tx_ready pulse per AES completion; never two pushes without an intervening aes_done.
- Reset mid-operation (e.g. in WAIT_AES) aborts immediately. A subsequent late aes_done in IDLE is ignored.

Optional Feature:
- Macro: SEQ_BYTE_TIMEOUT_EN.
- Defined:
  - In COLLECT, the timeout counter clears on each rx_valid and otherwise increments.
  - Reaching BYTE_TIMEOUT-1 discards the partial block: count=0, return to IDLE, no error flag.
- Undefined: COLLECT waits indefinitely; BYTE_TIMEOUT is unused.

Test Plan:
- Reset, then 16 rx_valid bytes 0x00..0x0F -> aes_block_in=128'h000102030405060708090A0B0C0D0E0F; aes_start pulse one cycle after byte 16; busy=1.
- AES model returns aes_done with aes_block_out=128'hDEADBEEF...(pattern) after 10 cycles, tx_overflow=0 -> block_to_tx=pattern; single tx_ready at the next cycle; back to IDLE; busy=0.
- Same as above but tx_overflow=1 for 5 cycles around PUSH -> tx_ready held low; exactly one pulse on the first cycle with tx_overflow=0.
- No aes_done for AES_TIMEOUT cycles -> aes_err=1, ERROR then IDLE; a following 16-byte block processes normally with aes_err still 1.
- rx_valid with byte 0xAA during WAIT_AES -> drop_err=1; block_to_tx unaffected; next block unaffected.
- With SEQ_BYTE_TIMEOUT_EN, BYTE_TIMEOUT=50: send 5 bytes, then idle 50 cycles -> IDLE, count=0, no flags; the next 16 bytes form a fresh block starting at [127:120]. Separately, assert reset during COLLECT -> all outputs 0 asynchronously.
